// File: rtl/pcx_core_arbiter.sv
// pcx_core_arbiter: shares one PCX path into ccx2max between up to four cores.
// Each core's PQ/PA request is captured into a per-core FIFO. Whole packets
// go downstream round-robin through one output register with a valid/stall
// handshake. Atomic pairs are never split. A grant returns to the
// originating core the cycle after its packet is accepted.
//
// state   | meaning
// ST_ARB  | round-robin pick among non-empty FIFOs
// ST_LOCK | first half of an atomic pair loaded; only lock_core may load
module pcx_core_arbiter #(
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int PCX_W      = 124
) (
  input  logic                       gclk,
  input  logic                       reset_l,
  input  logic [NUM_CORES*5-1:0]     core_req_pq,
  input  logic [NUM_CORES-1:0]       core_atom_pq,
  input  logic [NUM_CORES*PCX_W-1:0] core_data_pa,
  output logic [NUM_CORES*5-1:0]     core_grant_px,
  output logic [4:0]                 pcx_req,
  output logic                       pcx_atom,
  output logic [PCX_W-1:0]           pcx_data,
  output logic                       pcx_valid,
  input  logic                       pcx_stall,
  output logic [1:0]                 pcx_src,
  output logic [NUM_CORES-1:0]       fifo_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // FIFO entry layout: {req[4:0], atom, data}
  localparam int EW = PCX_W + 6;

  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

  logic [NUM_CORES-1:0] pend_valid;
  logic [4:0]           pend_req [NUM_CORES];
  logic [NUM_CORES-1:0] pend_atom;

  logic [EW-1:0] fifo_mem  [NUM_CORES][FIFO_DEPTH];
  logic [AW:0]   wr_ptr    [NUM_CORES];
  logic [AW:0]   rd_ptr    [NUM_CORES];
  logic [EW-1:0] fifo_head [NUM_CORES];
  logic [NUM_CORES-1:0] fifo_empty;
  logic [NUM_CORES-1:0] fifo_full;
  logic [NUM_CORES-1:0] fifo_push;
  logic [NUM_CORES-1:0] fifo_pop;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] lock_core;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] arb_cand;
  logic          win_found;
  logic [EW-1:0] win_head;
  logic          load_en;

  logic             out_valid;
  logic [4:0]       out_req;
  logic             out_atom;
  logic [PCX_W-1:0] out_data;
  logic [IW-1:0]    out_src;

  function automatic logic [IW-1:0] next_core(input logic [IW-1:0] idx);
    if (int'(idx) >= NUM_CORES - 1) return '0;
    return idx + IW'(1);
  endfunction

  // Latch destination and atomic flag in PQ; the data joins them in PA.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      pend_valid <= '0;
      pend_atom  <= '0;
      for (int i = 0; i < NUM_CORES; i++) pend_req[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        pend_valid[i] <= |core_req_pq[i*5 +: 5];
        pend_req[i]   <= core_req_pq[i*5 +: 5];
        pend_atom[i]  <= core_atom_pq[i];
      end
    end
  end

  // FIFO status; the extra pointer MSB separates full from empty.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
      fifo_full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                      (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      fifo_head[i]  = fifo_mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  // Pick the next packet: round-robin in ARB, only the locked core in LOCK.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_cand  = '0;
    if (state == ST_LOCK) begin
      win_found = !fifo_empty[lock_core];
      win_idx   = lock_core;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        arb_cand = IW'((int'(rr_ptr) + k) % NUM_CORES);
        if (!win_found && !fifo_empty[arb_cand]) begin
          win_found = 1'b1;
          win_idx   = arb_cand;
        end
      end
    end
    win_head = fifo_head[win_idx];
  end

  assign load_en = !out_valid || !pcx_stall;

  // Pop the winner whenever the output register can take a new packet.
  always_comb begin
    fifo_pop = '0;
    if (load_en && win_found) fifo_pop[win_idx] = 1'b1;
  end

  // A full FIFO still takes a write when its head leaves in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++)
      fifo_push[i] = pend_valid[i] && (!fifo_full[i] || fifo_pop[i]);
  end

  // FIFO pointers and the sticky overflow flags.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      fifo_overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (fifo_push[i]) wr_ptr[i] <= wr_ptr[i] + (AW+1)'(1);
        if (fifo_pop[i])  rd_ptr[i] <= rd_ptr[i] + (AW+1)'(1);
        if (pend_valid[i] && !fifo_push[i]) fifo_overflow[i] <= 1'b1;
      end
    end
  end

  // FIFO storage is not reset; the pointers define what is valid.
  always_ff @(posedge gclk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (fifo_push[i])
        fifo_mem[i][wr_ptr[i][AW-1:0]] <=
          {pend_req[i], pend_atom[i], core_data_pa[i*PCX_W +: PCX_W]};
    end
  end

  // Arbitration state, round-robin pointer and the output register.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= ST_ARB;
      rr_ptr    <= '0;
      lock_core <= '0;
      out_valid <= 1'b0;
      out_req   <= '0;
      out_atom  <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load_en) begin
      out_valid <= win_found;
      if (win_found) begin
        out_req  <= win_head[EW-1 -: 5];
        out_atom <= win_head[PCX_W];
        out_data <= win_head[PCX_W-1:0];
        out_src  <= win_idx;
        if (state == ST_ARB) begin
          if (win_head[PCX_W]) begin
            state     <= ST_LOCK;
            lock_core <= win_idx;
          end else begin
            rr_ptr <= next_core(win_idx);
          end
        end else begin
          // second half of the pair is out; resume fair arbitration
          state  <= ST_ARB;
          rr_ptr <= next_core(lock_core);
        end
      end
    end
  end

  // One-cycle grant to the source core after a downstream transfer.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      core_grant_px <= '0;
    end else begin
      core_grant_px <= '0;
      if (out_valid && !pcx_stall) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (out_src == IW'(i)) core_grant_px[i*5 +: 5] <= out_req;
        end
      end
    end
  end

  assign pcx_valid = out_valid;
  assign pcx_req   = out_req;
  assign pcx_atom  = out_atom;
  assign pcx_data  = out_data;
  assign pcx_src   = 2'(out_src);

endmodule

// File: doc/pcx_core_arbiter.md
# pcx_core_arbiter

Shares the single PCX path into `ccx2max` between up to four SPARC cores (`iop_fpga` instances), so that several cores can run on one Maxeler CCX link. Each core's PQ/PA request is captured into a small per-core FIFO. The block picks among the FIFOs round-robin and presents whole packets to the downstream PCX stage with a valid/stall handshake. Atomic pairs are never split. PCX grants go back to the originating core once its packet has been accepted downstream.

## Interface

- `NUM_CORES`, default 2: number of cores, 1–4.
- `FIFO_DEPTH`, default 4: entries per core FIFO, a power of 2 and at least 2.
- `PCX_W`, default 124: PCX packet width (`PCX_WIDTH`).
- `gclk` input, 1 bit: the single clock; all logic is on the rising edge.
- `reset_l` input, 1 bit: asynchronous, active-low reset.
- `core_req_pq` input, `NUM_CORES*5` bits: one-hot PCX destination request per core, in the PQ cycle.
- `core_atom_pq` input, `NUM_CORES` bits: per core, marks the current request as the first packet of an atomic pair.
- `core_data_pa` input, `NUM_CORES*PCX_W` bits: per-core packet, valid the cycle after its `req_pq`.
- `core_grant_px` output, `NUM_CORES*5` bits: per-core one-hot grant, a one-cycle pulse.
- `pcx_req` output, 5 bits: destination of the presented packet.
- `pcx_atom` output, 1 bit: the presented packet is the first packet of an atomic pair.
- `pcx_data` output, `PCX_W` bits: the presented packet.
- `pcx_valid` output, 1 bit: a packet is presented.
- `pcx_stall` input, 1 bit: the downstream stage cannot accept. A transfer occurs on any cycle with `pcx_valid && !pcx_stall`.
- `pcx_src` output, 2 bits: index of the core that issued the presented packet.
- `fifo_overflow` output, `NUM_CORES` bits: sticky per-core error flag.

## Operation

- **Capture.** A nonzero `core_req_pq[i]` in cycle t latches {dest, atom} into a per-core pending register. In cycle t+1, `core_data_pa[i]` is written into FIFO i together with the pending fields.
  - A new request in t+1 is legal (back-to-back requests). Its data comes in t+2.
- **Overflow.** If FIFO i is full when a write is due, the write is dropped and `fifo_overflow[i]` is set. The flag is cleared only by reset. Correct cores never overflow, because grants act as credits.
- **Output register.** One output register holds {`pcx_req`, `pcx_atom`, `pcx_data`, `pcx_src`}. It loads when it is empty or is transferring in the current cycle.
- **Arbitration.** Round-robin over non-empty FIFOs, starting at `rr_ptr`. After a non-atomic transfer from core i, `rr_ptr` becomes (i+1) mod `NUM_CORES`.
- **State machine**, states ARB and LOCK:
  - In ARB, the block picks the round-robin winner. If the head of the winner's FIFO has atom=1, it loads that head, records `lock_core = i` and moves to LOCK.
  - In LOCK, only FIFO `lock_core` may load. If that FIFO is empty, the output stays empty and other cores wait; the second packet arrives because the core issues pairs back-to-back.
  - Once the second packet has loaded, the block returns to ARB and `rr_ptr` becomes `lock_core`+1.
- **Grant.** On a transfer of a packet with source i and dest d, `core_grant_px[i] = d` in the following cycle. All other grant bits are 0.
- **Other boundaries.**
  - With `NUM_CORES = 1`, the block degenerates to a FIFO plus output register.
  - A non-one-hot `req_pq` is stored and forwarded unchanged; it is not checked.

## Timing

- Reset values: `pcx_valid` 0; `pcx_req`, `pcx_atom`, `pcx_data`, `pcx_src` 0; `core_grant_px` 0; `fifo_overflow` 0; all FIFOs empty; state ARB; `rr_ptr` 0; pending registers cleared.
- Reset applied mid-packet discards all buffered and in-flight packets. No grants are issued for them.
- Latency with an idle arbiter: `req_pq` at t, data at t+1, FIFO non-empty at t+2, `pcx_valid` at t+3. With no stall, the grant arrives at t+4.
- Throughput is one packet per cycle across cores when there is no stall.
- Outputs hold stable while `pcx_valid && pcx_stall`.
- FIFO read and write in the same cycle are both allowed when the FIFO is full: the read frees the slot, so no overflow.
- Pointer wrap-around uses an extra MSB so full and empty are distinguishable.

## Test plan

- Core 0 only, `req_pq = 5'b00001`, data `0xA5…`, no stall → `pcx_valid` at t+3 with `pcx_req = 00001`, `pcx_src = 0`; `core_grant_px[0] = 00001` at t+4.
- Cores 0 and 1 each issue 3 packets in the same cycles, no stall → output `pcx_src` order is 0,1,0,1,0,1, with 6 grants total.
- Core 1 issues an atomic pair (atom=1, then atom=0) while core 0 streams → core 1's two packets appear on consecutive transfers with no core-0 packet between them.
- Hold `pcx_stall = 1` for 10 cycles with the output loaded → `pcx_data` stays unchanged and there are no grants; after release, the queued packets drain in round-robin order.
- Core 0 issues `FIFO_DEPTH + 2` requests under continuous stall → `fifo_overflow[0] = 1` and stays 1. Then assert `reset_l = 0` mid-stream → all outputs are 0 on the next edge.
